// File: rtl/fnd_scan_driver.sv
// Round-robin 7-segment scan engine with per-slot blanking and frame-boundary register shadowing.
// Optional FND_DIM_EN adds a dim_level input that PWM-gates the anode during SHOW.
module fnd_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 100000,
   parameter int BLANK_CYCLES   = 16,
   parameter int SEG_ACTIVE_LOW = 1
) (
   input  logic                    s00_axi_aclk,
   input  logic                    s00_axi_aresetn,
   input  logic                    enable,
   input  logic [4*NUM_DIGITS-1:0] digit_data,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic                    upd_strobe,
`ifdef FND_DIM_EN
   input  logic [3:0]              dim_level,
`endif
   output logic [7:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_tick
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int DIG_W = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
   localparam logic             INV        = (SEG_ACTIVE_LOW != 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_SHOW  = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DIG_W-1:0]        digit_q, digit_d;
   logic                    pend_q, pend_d;
   logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d;
   logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
   logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
   logic [7:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    tick_q, tick_d;
   logic [3:0]              nib;
   logic                    an_gate;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

`ifdef FND_DIM_EN
   logic [3:0] pwm_cnt_q, pwm_cnt_d;

   always_comb begin
      pwm_cnt_d = pwm_cnt_q + 4'd1;
      an_gate   = ({1'b0, pwm_cnt_d} < ({1'b0, dim_level} + 5'd1));
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) pwm_cnt_q <= 4'd0;
      else                  pwm_cnt_q <= pwm_cnt_d;
   end
`else
   assign an_gate = 1'b1;
`endif

   // Next-state logic; shadow registers only change on enable or at the frame wrap.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      digit_d    = digit_q;
      pend_d     = pend_q | upd_strobe;
      sh_data_d  = sh_data_q;
      sh_dp_d    = sh_dp_q;
      sh_blank_d = sh_blank_q;
      tick_d     = 1'b0;
      if (!enable) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         digit_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d    = S_BLANK;
               cnt_d      = '0;
               digit_d    = '0;
               pend_d     = 1'b0;
               sh_data_d  = digit_data;
               sh_dp_d    = dp_mask;
               sh_blank_d = blank_mask;
            end
            S_BLANK: begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == BLANK_LAST) state_d = S_SHOW;
            end
            S_SHOW: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  state_d = S_BLANK;
                  if (digit_q == DIG_LAST) begin
                     digit_d = '0;
                     tick_d  = 1'b1;
                     if (pend_q || upd_strobe) begin
                        pend_d     = 1'b0;
                        sh_data_d  = digit_data;
                        sh_dp_d    = dp_mask;
                        sh_blank_d = blank_mask;
                     end
                  end else begin
                     digit_d = digit_q + DIG_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = '0;
               digit_d = '0;
            end
         endcase
      end
   end

   // Outputs are derived from the state being entered so they change on the same edge.
   always_comb begin
      nib  = sh_data_q[{digit_d, 2'b00} +: 4];
      an_d = '0;
      seg_d = 8'h00;
      if (state_d == S_SHOW) begin
         seg_d = {sh_dp_q[digit_d], hex7(nib)};
         if (!sh_blank_q[digit_d] && an_gate) an_d[digit_d] = 1'b1;
      end
      seg_d = seg_d ^ {8{INV}};
      an_d  = an_d ^ {NUM_DIGITS{INV}};
   end

   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         digit_q    <= '0;
         pend_q     <= 1'b0;
         sh_data_q  <= '0;
         sh_dp_q    <= '0;
         sh_blank_q <= '0;
         seg_q      <= {8{INV}};
         an_q       <= {NUM_DIGITS{INV}};
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         digit_q    <= digit_d;
         pend_q     <= pend_d;
         sh_data_q  <= sh_data_d;
         sh_dp_q    <= sh_dp_d;
         sh_blank_q <= sh_blank_d;
         seg_q      <= seg_d;
         an_q       <= an_d;
         tick_q     <= tick_d;
      end
   end

   assign seg        = seg_q;
   assign an         = an_q;
   assign frame_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Bench for fnd_scan_driver: frame-position model feeding an expected queue, plus literal pin checks.
module tb_fnd_scan_driver;

   localparam int N     = 4;
   localparam int S     = 8;
   localparam int B     = 2;
   localparam int FRAME = N * S;
   localparam logic [12:0] INACT = {8'hFF, 4'hF, 1'b0};

   logic          clk;
   logic          rst_n;
   logic          enable;
   logic [15:0]   digit_data;
   logic [3:0]    dp_mask;
   logic [3:0]    blank_mask;
   logic          upd_strobe;
   logic [7:0]    seg;
   logic [3:0]    an;
   logic          frame_tick;

   int n_cmp = 0;
   int n_bad = 0;
   logic [12:0] exp_q[$];

   fnd_scan_driver #(
      .NUM_DIGITS(N), .SCAN_DIV(S), .BLANK_CYCLES(B), .SEG_ACTIVE_LOW(1)
   ) dut (
      .s00_axi_aclk   (clk),
      .s00_axi_aresetn(rst_n),
      .enable         (enable),
      .digit_data     (digit_data),
      .dp_mask        (dp_mask),
      .blank_mask     (blank_mask),
      .upd_strobe     (upd_strobe),
`ifdef FND_DIM_EN
      .dim_level      (4'd15),
`endif
      .seg            (seg),
      .an             (an),
      .frame_tick     (frame_tick)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- model: output is a function of position in the frame ----------------
   logic [6:0]  seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   bit          m_run;
   int          m_t;
   bit          m_pend;
   logic [15:0] m_data;
   logic [3:0]  m_dp, m_blank;
   logic        m_ft;
   logic [7:0]  m_seg;
   logic [3:0]  m_an;
   int          m_off, m_dig;

   always @(posedge clk) begin
      m_ft = 1'b0;
      if (!rst_n) begin
         m_run = 0; m_t = 0; m_pend = 0;
         m_data = '0; m_dp = '0; m_blank = '0;
         exp_q.push_back(INACT);
      end else if (!enable) begin
         m_run = 0; m_t = 0;
         exp_q.push_back(INACT);
      end else begin
         if (!m_run) begin
            m_run = 1; m_t = 0; m_pend = 0;
            m_data = digit_data; m_dp = dp_mask; m_blank = blank_mask;
         end else begin
            m_t++;
            if (m_t % FRAME == 0) begin
               m_ft = 1'b1;
               if (m_pend || upd_strobe) begin
                  m_data = digit_data; m_dp = dp_mask; m_blank = blank_mask;
                  m_pend = 0;
               end
            end else if (upd_strobe) begin
               m_pend = 1;
            end
         end
         m_off = m_t % S;
         m_dig = (m_t / S) % N;
         m_seg = 8'h00;
         m_an  = 4'h0;
         if (m_off >= B) begin
            m_seg = {m_dp[m_dig], seg_tab[m_data[m_dig*4 +: 4]]};
            if (!m_blank[m_dig]) m_an = 4'(1 << m_dig);
         end
         exp_q.push_back({~m_seg, ~m_an, m_ft});
      end
   end

   // ---------------- scoreboard compare ----------------
   logic [12:0] e_now;
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e_now = exp_q.pop_front();
         n_cmp++;
         if ({seg, an, frame_tick} !== e_now) begin
            n_bad++;
            $display("FAIL cycle_model t=%0t: got seg=%h an=%b ft=%b expected seg=%h an=%b ft=%b",
                     $time, seg, an, frame_tick, e_now[12:5], e_now[4:1], e_now[0]);
         end
      end
   end

   // ---------------- driver / literal-check tasks ----------------
   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, got, want);
      end
   endtask

   task automatic wait_an(input logic [3:0] want, input string nm);
      int n;
      n = 0;
      while (an !== want && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_reached"}, {12'h0, an}, {12'h0, want});
   endtask

   task automatic wait_ft(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_tick !== 1'b1 && n < 100);
      chk({nm, "_tick_seen"}, {15'h0, frame_tick}, 16'h0001);
   endtask

   task automatic latency(input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (an === 4'hF && n < 20);
      chk(nm, 16'(n), 16'(B + 1));
   endtask

   task automatic write_regs(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
      digit_data = d; dp_mask = dp; blank_mask = bl; upd_strobe = 1'b1;
      @(negedge clk);
      upd_strobe = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin : main
      int n;
      logic [3:0] low_seen;
      rst_n = 1'b0; enable = 1'b1; upd_strobe = 1'b0;
      digit_data = 16'h12AF; dp_mask = 4'b0100; blank_mask = 4'b0000;

      repeat (5) begin
         @(negedge clk);
         chk("reset_seg", {8'h0, seg}, 16'h00FF);
         chk("reset_an", {12'h0, an}, 16'h000F);
         chk("reset_ft", {15'h0, frame_tick}, 16'h0000);
      end
      rst_n = 1'b1;

      latency("start_latency");
      chk("d0_an", {12'h0, an}, 16'h000E);
      chk("d0_seg_F", {8'h0, seg}, 16'h008E);
      wait_an(4'b1101, "d1");
      chk("d1_seg_A", {8'h0, seg}, 16'h0088);
      wait_an(4'b1011, "d2");
      chk("d2_seg_2dp", {8'h0, seg}, 16'h0024);
      wait_an(4'b0111, "d3");
      chk("d3_seg_1", {8'h0, seg}, 16'h00F9);

      wait_ft("period_a");
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_tick !== 1'b1 && n < 100);
      chk("frame_period", 16'(n), 16'(FRAME));

      // mid-frame write while digit 1 is lit: rest of frame keeps old digits
      wait_an(4'b1101, "mid_d1");
      write_regs(16'h0000, 4'b0000, 4'b0000);
      wait_an(4'b1011, "mid_d2");
      chk("mid_old_d2", {8'h0, seg}, 16'h0024);
      wait_an(4'b0111, "mid_d3");
      chk("mid_old_d3", {8'h0, seg}, 16'h00F9);
      wait_an(4'b1110, "new_d0");
      chk("new_d0_zero", {8'h0, seg}, 16'h00C0);

      // strobe coincident with the wrap edge
      wait_ft("wrap_ref");
      repeat (FRAME - 1) @(negedge clk);
      write_regs(16'h5555, 4'b0000, 4'b0000);
      chk("wrap_tick", {15'h0, frame_tick}, 16'h0001);
      wait_an(4'b1110, "wrap_d0");
      chk("wrap_applied", {8'h0, seg}, 16'h0092);

      // blank mask on digits 1 and 3
      write_regs(16'h5555, 4'b0000, 4'b1010);
      wait_ft("blank_apply");
      wait_ft("blank_ref");
      n = 0; low_seen = 4'h0;
      repeat (FRAME) begin
         @(negedge clk);
         if (an !== 4'hF) n++;
         low_seen = low_seen | ~an;
      end
      chk("blank_on_cycles", 16'(n), 16'd12);
      chk("blank_digits_dark", {12'h0, low_seen & 4'b1010}, 16'h0000);
      chk("blank_period_tick", {15'h0, frame_tick}, 16'h0001);

      // enable drop during digit 2 SHOW, then re-enable
      write_regs(16'h5555, 4'b0000, 4'b0000);
      wait_ft("unblank_apply");
      wait_an(4'b1011, "drop_d2");
      enable = 1'b0;
      @(negedge clk);
      chk("drop_an", {12'h0, an}, 16'h000F);
      chk("drop_seg", {8'h0, seg}, 16'h00FF);
      repeat (3) @(negedge clk);
      enable = 1'b1;
      latency("reenable_latency");
      chk("reenable_d0", {12'h0, an}, 16'h000E);

      // reset mid-scan
      wait_an(4'b1101, "rst_d1");
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_an", {12'h0, an}, 16'h000F);
      chk("midrst_seg", {8'h0, seg}, 16'h00FF);
      @(negedge clk);
      rst_n = 1'b1;

      // random register writes at random times
      repeat (8) begin
         repeat ($urandom_range(1, 40)) @(negedge clk);
         write_regs(16'($urandom()), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      repeat (3 * FRAME) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule
